vpu_op_sched: RTL and testbench

VPU_OP_SCHED -- requirements
Module: vpu_op_sched

---
 rtl/vpu_op_sched_if.sv | 37 +++
 rtl/vpu_op_sched.sv | 140 ++++++++++++++
 tb/tb_vpu_op_sched.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vpu_op_sched_if.sv
// Command / unit / response bundle for vpu_op_sched.
//   master: command producer and unit model (drives i_*, observes o_*)
//   slave : the scheduler itself (observes i_*, drives o_*)
// Signals:
//   i_cmd_vld/o_cmd_rdy          command handshake
//   i_cmd_unit/level/tag         command payload
//   o_start[NUM_UNITS]           one-hot start pulse per unit
//   i_done[NUM_UNITS]            unit idle level (high = idle)
//   o_level                      level presented to all units
//   o_busy                       queue non-empty or sequencer active
//   o_rsp_vld/o_rsp_tag/o_rsp_err completion pulse with tag and error flag
interface vpu_op_sched_if #(
    parameter int NUM_UNITS = 3
);
    logic                 i_cmd_vld;
    logic                 o_cmd_rdy;
    logic [1:0]           i_cmd_unit;
    logic [3:0]           i_cmd_level;
    logic [3:0]           i_cmd_tag;
    logic [NUM_UNITS-1:0] o_start;
    logic [NUM_UNITS-1:0] i_done;
    logic [3:0]           o_level;
    logic                 o_busy;
    logic                 o_rsp_vld;
    logic [3:0]           o_rsp_tag;
    logic                 o_rsp_err;

    modport master (
        output i_cmd_vld, i_cmd_unit, i_cmd_level, i_cmd_tag, i_done,
        input  o_cmd_rdy, o_start, o_level, o_busy, o_rsp_vld, o_rsp_tag, o_rsp_err
    );

    modport slave (
        input  i_cmd_vld, i_cmd_unit, i_cmd_level, i_cmd_tag, i_done,
        output o_cmd_rdy, o_start, o_level, o_busy, o_rsp_vld, o_rsp_tag, o_rsp_err
    );
endinterface

// File: rtl/vpu_op_sched.sv
// VPU operation scheduler: queues commands in a FIFO and sequences them one
// at a time onto NUM_UNITS units via a start pulse / done-level handshake.
// Ports:
//   clk   - clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - vpu_op_sched_if.slave (command, unit handshake, response)
// Sequence per command: IDLE (pop) -> ISSUE (start pulse) -> ACK (wait for
// done to drop, bounded by ACK_TIMEOUT) -> RUN (wait for done to rise) ->
// RESP (one-cycle response). Invalid commands go straight from IDLE to RESP.
// FIFO_DEPTH must be a power of two, at least 2.
module vpu_op_sched #(
    parameter int NUM_UNITS   = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 8,
    parameter int LEVEL_MAX   = 12
) (
    input logic           clk,
    input logic           rst_n,
    vpu_op_sched_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ACK,
        RUN,
        RESP
    } state_t;

    state_t state, state_nxt;

    // Entry layout: {unit[1:0], level[3:0], tag[3:0]}
    logic [9:0]           mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 full, empty, push, pop;
    logic [1:0]           head_unit;
    logic [3:0]           head_level, head_tag;
    logic                 head_ok;

    logic [1:0]           cur_unit;
    logic [3:0]           cur_tag;
    logic [3:0]           level_q;
    logic                 cur_err;
    logic [CW-1:0]        ack_cnt;
    logic                 ack_expired;
    logic                 sel_done;
    logic [NUM_UNITS-1:0] start_vec;

    // Extra wrap bit: equal pointers = empty, differing only in MSB = full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.i_cmd_vld && !full;

    assign {head_unit, head_level, head_tag} = mem[rd_ptr[AW-1:0]];
    assign head_ok = (int'(head_unit) < NUM_UNITS) && (int'(head_level) <= LEVEL_MAX);

    assign ack_expired = (ack_cnt == CW'(ACK_TIMEOUT - 1));

    // Only the done bit of the unit currently being sequenced matters.
    always_comb begin
        sel_done = 1'b0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            if (cur_unit == 2'(u)) sel_done = bus.i_done[u];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        start_vec = '0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = head_ok ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                for (int unsigned u = 0; u < NUM_UNITS; u++) begin
                    if (cur_unit == 2'(u)) start_vec[u] = 1'b1;
                end
                state_nxt = ACK;
            end
            ACK: begin
                if (!sel_done)        state_nxt = RUN;
                else if (ack_expired) state_nxt = RESP;
            end
            RUN: begin
                if (sel_done) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {bus.i_cmd_unit, bus.i_cmd_level, bus.i_cmd_tag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cur_unit <= '0;
            cur_tag  <= '0;
            cur_err  <= 1'b0;
            level_q  <= '0;
            ack_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                cur_unit <= head_unit;
                cur_tag  <= head_tag;
                cur_err  <= !head_ok;
                // A rejected command must not disturb the level seen by units.
                if (head_ok) level_q <= head_level;
            end
            if (state == ISSUE)    ack_cnt <= '0;
            else if (state == ACK) ack_cnt <= ack_cnt + 1'b1;
            if (state == ACK && sel_done && ack_expired) cur_err <= 1'b1;
        end
    end

    // o_start decodes the state register directly so it drops with rst_n.
    assign bus.o_cmd_rdy = !full;
    assign bus.o_start   = start_vec;
    assign bus.o_level   = level_q;
    assign bus.o_busy    = !empty || (state != IDLE);
    assign bus.o_rsp_vld = (state == RESP);
    assign bus.o_rsp_tag = cur_tag;
    assign bus.o_rsp_err = cur_err;
endmodule

// File: tb/tb_vpu_op_sched.sv
// Directed self-checking bench for vpu_op_sched.
module tb_vpu_op_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    vpu_op_sched_if #(.NUM_UNITS(3)) bus ();

    vpu_op_sched #(
        .NUM_UNITS(3),
        .FIFO_DEPTH(4),
        .ACK_TIMEOUT(8),
        .LEVEL_MAX(12)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Observed responses and start pulses, sampled on the falling edge.
    logic [3:0] rsp_tag_q[$];
    logic       rsp_err_q[$];
    int         rsp_cyc_q[$];
    logic [2:0] start_q[$];
    int         start_cyc_q[$];

    always @(negedge clk) begin
        if (bus.o_rsp_vld === 1'b1) begin
            rsp_tag_q.push_back(bus.o_rsp_tag);
            rsp_err_q.push_back(bus.o_rsp_err);
            rsp_cyc_q.push_back(cyc);
        end
        if (bus.o_start !== 3'b000) begin
            start_q.push_back(bus.o_start);
            start_cyc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        rsp_tag_q.delete();
        rsp_err_q.delete();
        rsp_cyc_q.delete();
        start_q.delete();
        start_cyc_q.delete();
    endtask

    // Offers a command until accepted; waited = cycles spent with rdy low,
    // acc_cyc = cycle count at the falling edge just before the accepting edge.
    task automatic push_cmd(input logic [1:0] u, input logic [3:0] lv, input logic [3:0] tg,
                            output int waited, output int acc_cyc);
        bus.i_cmd_vld   = 1'b1;
        bus.i_cmd_unit  = u;
        bus.i_cmd_level = lv;
        bus.i_cmd_tag   = tg;
        waited = 0;
        while (bus.o_cmd_rdy !== 1'b1 && waited < 300) begin
            tick();
            waited++;
        end
        acc_cyc = cyc;
        tick();
        bus.i_cmd_vld = 1'b0;
    endtask

    task automatic wait_rsps(input int n, input int bound, output bit ok);
        int k = 0;
        while (rsp_tag_q.size() < n && k < bound) begin
            tick();
            k++;
        end
        ok = (rsp_tag_q.size() >= n);
    endtask

    task automatic wait_start(input int bound, output bit ok);
        int k = 0;
        while (start_q.size() == 0 && k < bound) begin
            tick();
            k++;
        end
        ok = (start_q.size() != 0);
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.i_cmd_vld   = 1'b0;
        bus.i_cmd_unit  = '0;
        bus.i_cmd_level = '0;
        bus.i_cmd_tag   = '0;
        bus.i_done      = 3'b111;
        #12;
        total_cnt++; if (bus.o_start !== 3'b000) $display("FAIL reset_start: got %b want 000", bus.o_start); else pass_cnt++;
        total_cnt++; if (bus.o_level !== 4'd0) $display("FAIL reset_level: got %0d want 0", bus.o_level); else pass_cnt++;
        total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.o_busy); else pass_cnt++;
        total_cnt++; if (bus.o_rsp_vld !== 1'b0) $display("FAIL reset_rsp_vld: got %b want 0", bus.o_rsp_vld); else pass_cnt++;
        total_cnt++; if (bus.o_rsp_tag !== 4'd0) $display("FAIL reset_rsp_tag: got %0d want 0", bus.o_rsp_tag); else pass_cnt++;
        total_cnt++; if (bus.o_rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", bus.o_rsp_err); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++; if (bus.o_cmd_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", bus.o_cmd_rdy); else pass_cnt++;
        total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", bus.o_busy); else pass_cnt++;
    endtask

    task automatic test_single();
        int w, a;
        bit ok;
        bit bad = 1'b0;
        clr();
        push_cmd(2'd2, 4'd5, 4'd3, w, a);
        wait_start(20, ok);
        total_cnt++; if (!ok) $display("FAIL single_start_seen: got none want 100"); else pass_cnt++;
        if (ok) begin
            total_cnt++; if (start_q[0] !== 3'b100) $display("FAIL single_start_vec: got %b want 100", start_q[0]); else pass_cnt++;
            total_cnt++; if (start_cyc_q[0] - a !== 2) $display("FAIL single_latency: got %0d want 2", start_cyc_q[0] - a); else pass_cnt++;
        end
        total_cnt++; if (bus.o_level !== 4'd5) $display("FAIL single_level_issue: got %0d want 5", bus.o_level); else pass_cnt++;
        tick();
        total_cnt++; if (bus.o_start !== 3'b000) $display("FAIL single_start_width: got %b want 000", bus.o_start); else pass_cnt++;
        bus.i_done[2] = 1'b0;
        repeat (100) begin
            tick();
            if (bus.o_level !== 4'd5 || bus.o_start !== 3'b000 || bus.o_rsp_vld !== 1'b0) bad = 1'b1;
        end
        total_cnt++; if (bad !== 1'b0) $display("FAIL single_run_stable: got %b want 0", bad); else pass_cnt++;
        bus.i_done[2] = 1'b1;
        wait_rsps(1, 10, ok);
        total_cnt++; if (!ok) $display("FAIL single_rsp_seen: got 0 want 1"); else pass_cnt++;
        if (ok) begin
            total_cnt++; if (rsp_tag_q[0] !== 4'd3) $display("FAIL single_rsp_tag: got %0d want 3", rsp_tag_q[0]); else pass_cnt++;
            total_cnt++; if (rsp_err_q[0] !== 1'b0) $display("FAIL single_rsp_err: got %b want 0", rsp_err_q[0]); else pass_cnt++;
        end
        total_cnt++; if (bus.o_level !== 4'd5) $display("FAIL single_level_resp: got %0d want 5", bus.o_level); else pass_cnt++;
        total_cnt++; if (start_q.size() !== 1) $display("FAIL single_start_count: got %0d want 1", start_q.size()); else pass_cnt++;
        tick();
        total_cnt++; if (bus.o_rsp_vld !== 1'b0) $display("FAIL single_rsp_pulse: got %b want 0", bus.o_rsp_vld); else pass_cnt++;
        total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", bus.o_busy); else pass_cnt++;
    endtask

    // Units never acknowledge, so every command times out; one command is in
    // flight before the five back-to-back pushes so the queue really fills.
    task automatic test_fill();
        int w, a, wsum;
        bit ok;
        clr();
        bus.i_done = 3'b111;
        push_cmd(2'd0, 4'd9, 4'd0, w, a);
        wsum = 0;
        for (int i = 1; i <= 4; i++) begin
            push_cmd(2'd0, 4'd9, 4'(i), w, a);
            wsum += w;
        end
        total_cnt++; if (wsum !== 0) $display("FAIL fill_first4_wait: got %0d want 0", wsum); else pass_cnt++;
        push_cmd(2'd1, 4'd9, 4'd5, w, a);
        total_cnt++; if (!(w > 0 && w < 300)) $display("FAIL fill_fifth_held: got %0d want 1..299", w); else pass_cnt++;
        wait_rsps(6, 200, ok);
        total_cnt++; if (!ok) $display("FAIL fill_rsp_count: got %0d want 6", rsp_tag_q.size()); else pass_cnt++;
        if (ok) begin
            for (int i = 0; i < 6; i++) begin
                total_cnt++; if (rsp_tag_q[i] !== 4'(i)) $display("FAIL fill_order[%0d]: got %0d want %0d", i, rsp_tag_q[i], i); else pass_cnt++;
                total_cnt++; if (rsp_err_q[i] !== 1'b1) $display("FAIL fill_err[%0d]: got %b want 1", i, rsp_err_q[i]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_invalid();
        int w, a;
        bit ok;
        clr();
        push_cmd(2'd3, 4'd1, 4'd7, w, a);
        push_cmd(2'd0, 4'd13, 4'd8, w, a);
        wait_rsps(2, 30, ok);
        total_cnt++; if (!ok) $display("FAIL inv_rsp_count: got %0d want 2", rsp_tag_q.size()); else pass_cnt++;
        if (ok) begin
            total_cnt++; if (rsp_tag_q[0] !== 4'd7 || rsp_err_q[0] !== 1'b1) $display("FAIL inv_rsp0: got tag %0d err %b want tag 7 err 1", rsp_tag_q[0], rsp_err_q[0]); else pass_cnt++;
            total_cnt++; if (rsp_tag_q[1] !== 4'd8 || rsp_err_q[1] !== 1'b1) $display("FAIL inv_rsp1: got tag %0d err %b want tag 8 err 1", rsp_tag_q[1], rsp_err_q[1]); else pass_cnt++;
        end
        total_cnt++; if (start_q.size() !== 0) $display("FAIL inv_no_start: got %0d want 0", start_q.size()); else pass_cnt++;
        total_cnt++; if (bus.o_level !== 4'd9) $display("FAIL inv_level_kept: got %0d want 9", bus.o_level); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int w, a;
        bit ok;
        clr();
        bus.i_done = 3'b111;
        push_cmd(2'd1, 4'd4, 4'd10, w, a);
        wait_start(20, ok);
        total_cnt++; if (!ok || start_q[0] !== 3'b010) $display("FAIL to_start: got %b want 010", ok ? start_q[0] : 3'b000); else pass_cnt++;
        wait_rsps(1, 30, ok);
        total_cnt++; if (!ok) $display("FAIL to_rsp_seen: got 0 want 1"); else pass_cnt++;
        if (ok) begin
            total_cnt++; if (rsp_tag_q[0] !== 4'd10 || rsp_err_q[0] !== 1'b1) $display("FAIL to_rsp: got tag %0d err %b want tag 10 err 1", rsp_tag_q[0], rsp_err_q[0]); else pass_cnt++;
            // ACK is entered one cycle after the start pulse, response 8 cycles later.
            total_cnt++; if (rsp_cyc_q[0] - start_cyc_q[0] !== 9) $display("FAIL to_timing: got %0d want 9", rsp_cyc_q[0] - start_cyc_q[0]); else pass_cnt++;
        end
        clr();
        push_cmd(2'd0, 4'd2, 4'd11, w, a);
        wait_start(20, ok);
        total_cnt++; if (!ok || start_q[0] !== 3'b001) $display("FAIL to_next_start: got %b want 001", ok ? start_q[0] : 3'b000); else pass_cnt++;
        tick();
        bus.i_done[0] = 1'b0;
        repeat (3) tick();
        bus.i_done[0] = 1'b1;
        wait_rsps(1, 10, ok);
        total_cnt++; if (!ok || rsp_tag_q[0] !== 4'd11 || rsp_err_q[0] !== 1'b0) $display("FAIL to_next_rsp: got tag %0d err %b want tag 11 err 0", ok ? rsp_tag_q[0] : 4'd0, ok ? rsp_err_q[0] : 1'b1); else pass_cnt++;
        total_cnt++; if (bus.o_level !== 4'd2) $display("FAIL to_next_level: got %0d want 2", bus.o_level); else pass_cnt++;
    endtask

    task automatic test_ignore_other();
        int w, a;
        bit ok;
        clr();
        bus.i_done = 3'b111;
        push_cmd(2'd1, 4'd6, 4'd12, w, a);
        wait_start(20, ok);
        total_cnt++; if (!ok || start_q[0] !== 3'b010) $display("FAIL ign_start: got %b want 010", ok ? start_q[0] : 3'b000); else pass_cnt++;
        tick();
        bus.i_done[1] = 1'b0;
        repeat (12) begin
            bus.i_done[0] = ~bus.i_done[0];
            bus.i_done[2] = ~bus.i_done[2];
            tick();
        end
        total_cnt++; if (rsp_tag_q.size() !== 0) $display("FAIL ign_no_rsp: got %0d want 0", rsp_tag_q.size()); else pass_cnt++;
        total_cnt++; if (bus.o_busy !== 1'b1) $display("FAIL ign_busy: got %b want 1", bus.o_busy); else pass_cnt++;
        total_cnt++; if (start_q.size() !== 1) $display("FAIL ign_start_count: got %0d want 1", start_q.size()); else pass_cnt++;
        bus.i_done = 3'b111;
        wait_rsps(1, 10, ok);
        total_cnt++; if (!ok || rsp_tag_q[0] !== 4'd12 || rsp_err_q[0] !== 1'b0) $display("FAIL ign_rsp: got tag %0d err %b want tag 12 err 0", ok ? rsp_tag_q[0] : 4'd0, ok ? rsp_err_q[0] : 1'b1); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int w, a;
        bit ok;
        clr();
        bus.i_done = 3'b111;
        push_cmd(2'd0, 4'd3, 4'd1, w, a);
        wait_start(20, ok);
        tick();
        bus.i_done[0] = 1'b0;
        tick();
        push_cmd(2'd0, 4'd3, 4'd2, w, a);
        push_cmd(2'd0, 4'd3, 4'd3, w, a);
        total_cnt++; if (bus.o_busy !== 1'b1 || bus.o_level !== 4'd3) $display("FAIL rm_pre: got busy %b level %0d want busy 1 level 3", bus.o_busy, bus.o_level); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.o_start !== 3'b000) $display("FAIL rm_start: got %b want 000", bus.o_start); else pass_cnt++;
        total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", bus.o_busy); else pass_cnt++;
        total_cnt++; if (bus.o_level !== 4'd0) $display("FAIL rm_level: got %0d want 0", bus.o_level); else pass_cnt++;
        total_cnt++; if (bus.o_rsp_tag !== 4'd0 || bus.o_rsp_vld !== 1'b0 || bus.o_rsp_err !== 1'b0) $display("FAIL rm_rsp: got vld %b tag %0d err %b want 0 0 0", bus.o_rsp_vld, bus.o_rsp_tag, bus.o_rsp_err); else pass_cnt++;
        tick();
        tick();
        bus.i_done = 3'b111;
        rst_n = 1'b1;
        repeat (10) tick();
        total_cnt++; if (rsp_tag_q.size() !== 0) $display("FAIL rm_no_rsp: got %0d want 0", rsp_tag_q.size()); else pass_cnt++;
        total_cnt++; if (start_q.size() !== 1) $display("FAIL rm_no_restart: got %0d want 1", start_q.size()); else pass_cnt++;
        total_cnt++; if (bus.o_busy !== 1'b0 || bus.o_cmd_rdy !== 1'b1) $display("FAIL rm_empty: got busy %b rdy %b want 0 1", bus.o_busy, bus.o_cmd_rdy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_invalid();
        test_timeout();
        test_ignore_other();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
